// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and fills the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pcf, pcf_next, pcplus4f;
  logic [31:0] instr_next, pcd_next, pcplus4d_next;
  logic        valid_next, fault_next;

  assign imem_addr = pcf;
  assign pcplus4f  = pcf + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      pcf         <= RESET_PC;
      InstrD      <= NOP_INSTR;
      PCD         <= 32'd0;
      PCPlus4D    <= 32'd0;
      ValidD      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pcf         <= pcf_next;
      InstrD      <= instr_next;
      PCD         <= pcd_next;
      PCPlus4D    <= pcplus4d_next;
      ValidD      <= valid_next;
      fetch_fault <= fault_next;
    end
  end

  // A redirect wins over StallF; a misaligned target leaves the PC alone and parks the stage in HALT.
  always_comb begin
    state_next    = state;
    pcf_next      = pcf;
    instr_next    = InstrD;
    pcd_next      = PCD;
    pcplus4d_next = PCPlus4D;
    valid_next    = ValidD;
    fault_next    = fetch_fault;
    case (state)
      RUN: begin
        if (PCSrcE) begin
          if (PCTargetE[1:0] == 2'b00) begin
            pcf_next = PCTargetE;
          end else begin
            fault_next = 1'b1;
            state_next = HALT;
          end
        end else if (!StallF) begin
          pcf_next = pcplus4f;
        end
        if (FlushD) begin
          instr_next    = NOP_INSTR;
          pcd_next      = 32'd0;
          pcplus4d_next = 32'd0;
          valid_next    = 1'b0;
        end else if (!StallD) begin
          instr_next    = imem_rdata;
          pcd_next      = pcf;
          pcplus4d_next = pcplus4f;
          valid_next    = 1'b1;
        end
      end
      HALT: begin
        instr_next    = NOP_INSTR;
        pcd_next      = 32'd0;
        pcplus4d_next = 32'd0;
        valid_next    = 1'b0;
        fault_next    = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  // Every non-reset edge is either a real fetch into IF/ID or a bubble/hold.
  logic do_fetch;
  assign do_fetch = (state == RUN) && !FlushD && !StallD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else if (do_fetch) begin
      fetch_cnt  <= fetch_cnt + 32'd1;
    end else begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level reference model queues expected outputs, a monitor compares them.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        ValidD, fetch_fault;
  logic [31:0] fetch_cnt_w, bubble_cnt_w;

  logic [31:0] wrap_addr, wrap_rdata, wrap_instr, wrap_pcd, wrap_pc4d;
  logic        wrap_valid, wrap_fault;
  logic [31:0] wrap_fcnt, wrap_bcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'hFFC4A303;
      32'h4:   mem_word = 32'h00832383;
      32'h8:   mem_word = 32'h0064A423;
      default: mem_word = (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign wrap_rdata = mem_word(wrap_addr);

`ifndef FETCH_PERF_CNT_EN
  assign fetch_cnt_w  = 32'd0;
  assign bubble_cnt_w = 32'd0;
  assign wrap_fcnt    = 32'd0;
  assign wrap_bcnt    = 32'd0;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt_w), .bubble_cnt(bubble_cnt_w)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'h0), .imem_addr(wrap_addr), .imem_rdata(wrap_rdata),
    .InstrD(wrap_instr), .PCD(wrap_pcd), .PCPlus4D(wrap_pc4d), .ValidD(wrap_valid),
    .fetch_fault(wrap_fault)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(wrap_fcnt), .bubble_cnt(wrap_bcnt)
`endif
  );

  typedef struct {
    logic [31:0] addr, instr, pcd, pc4d, fcnt, bcnt;
    logic        valid, fault;
  } exp_t;

  exp_t expq[$];

  // Reference model state: architectural view of the stage after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_fcnt, m_bcnt;
  logic        m_valid, m_fault, m_halted;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("imem_addr", imem_addr, e.addr);
    cmp("InstrD", InstrD, e.instr);
    cmp("PCD", PCD, e.pcd);
    cmp("PCPlus4D", PCPlus4D, e.pc4d);
    cmp("ValidD", {31'd0, ValidD}, {31'd0, e.valid});
    cmp("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
`ifdef FETCH_PERF_CNT_EN
    cmp("fetch_cnt", fetch_cnt_w, e.fcnt);
    cmp("bubble_cnt", bubble_cnt_w, e.bcnt);
`endif
  endtask

  // Drive one cycle of inputs, advance the model by one edge, queue its prediction, then step the clock.
  task automatic applyStimulus(input logic r, input logic sf, input logic sd, input logic fd,
                               input logic ps, input logic [31:0] tgt);
    logic [31:0] old_pc;
    exp_t e;
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    old_pc = m_pc;
    if (!r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_fcnt = 32'h0; m_bcnt = 32'h0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
      m_bcnt = m_bcnt + 1;
    end else begin
      if (ps && tgt % 4 == 0) m_pc = tgt;
      else if (ps) begin m_fault = 1'b1; m_halted = 1'b1; end
      else if (!sf) m_pc = old_pc + 4;
      if (fd) begin
        m_instr = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
        m_bcnt = m_bcnt + 1;
      end else if (sd) begin
        m_bcnt = m_bcnt + 1;
      end else begin
        m_instr = mem_word(old_pc); m_pcd = old_pc; m_pc4d = old_pc + 4; m_valid = 1'b1;
        m_fcnt = m_fcnt + 1;
      end
    end
    e.addr = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4d = m_pc4d;
    e.valid = m_valid; e.fault = m_fault; e.fcnt = m_fcnt; e.bcnt = m_bcnt;
    expq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one prediction is consumed per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic r, sf, sd, fd, ps;
    logic [31:0] tgt;
    m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4d = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_fcnt = 32'h0; m_bcnt = 32'h0;
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    cmp("wrap_reset_addr", wrap_addr, 32'hFFFF_FFFC);
    cmp("wrap_reset_valid", {31'd0, wrap_valid}, 32'd0);

    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    cmp("wrap_addr", wrap_addr, 32'h0);
    cmp("wrap_pcplus4d", wrap_pc4d, 32'h0);
    cmp("wrap_pcd", wrap_pcd, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    applyStimulus(1, 1, 0, 1, 1, 32'h40);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    applyStimulus(1, 0, 0, 0, 1, 32'h42);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    applyStimulus(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 29) != 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fd  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 5) == 0);
      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(r, sf, sd, fd, ps, tgt);
    end

    @(posedge clk);
    #2;
    cmp("scoreboard_drained", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
